// File: rtl/gpio_apb_irq.sv
// APB GPIO controller: per-pin direction, atomic set/clear, synchronised inputs and
// per-pin edge interrupts with a single level irq output.
`timescale 1ns/1ps
module gpio_apb_irq #(
   parameter int unsigned NUM_PINS    = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [31:0]         in_paddr,
   input  logic                in_psel,
   input  logic                in_penable,
   input  logic [2:0]          in_pprot,
   input  logic                in_pwrite,
   input  logic [31:0]         in_pwdata,
   input  logic [3:0]          in_pstrb,
   output logic                in_pready,
   output logic [31:0]         in_prdata,
   output logic                in_pslverr,
   input  logic [NUM_PINS-1:0] gpio_in,
   output logic [NUM_PINS-1:0] gpio_out,
   output logic [NUM_PINS-1:0] gpio_oe,
   output logic                irq
);

   localparam logic [2:0] AddrOut    = 3'd0;
   localparam logic [2:0] AddrIn     = 3'd1;
   localparam logic [2:0] AddrDir    = 3'd2;
   localparam logic [2:0] AddrIrqEn  = 3'd3;
   localparam logic [2:0] AddrRise   = 3'd4;
   localparam logic [2:0] AddrStat   = 3'd5;
   localparam logic [2:0] AddrOutSet = 3'd6;
   localparam logic [2:0] AddrOutClr = 3'd7;

   typedef enum logic {StIdle, StAccess} state_t;

   state_t              r_state;
   logic                r_pready;
   logic                r_pslverr;
   logic [31:0]         r_prdata;
   logic                r_irq;
   logic [NUM_PINS-1:0] r_out;
   logic [NUM_PINS-1:0] r_dir;
   logic [NUM_PINS-1:0] r_en;
   logic [NUM_PINS-1:0] r_rise;
   logic [NUM_PINS-1:0] r_stat;
   logic [NUM_PINS-1:0] r_prev;
   logic [NUM_PINS-1:0] r_sync [SYNC_STAGES];

   logic [2:0]          w_addr;
   logic                w_access;
   logic                w_wr;
   logic [31:0]         w_bmask;
   logic [31:0]         w_wmask;
   logic [NUM_PINS-1:0] w_bm;
   logic [NUM_PINS-1:0] w_wd;
   logic [NUM_PINS-1:0] w_sync;
   logic [NUM_PINS-1:0] w_edge;
   logic [NUM_PINS-1:0] w_w1c;
   logic [31:0]         w_rdata;
   logic                w_unused;

   assign w_addr   = in_paddr[4:2];
   assign w_access = (r_state == StAccess) && in_psel && in_penable;
   assign w_wr     = w_access && in_pwrite;
   assign w_bmask  = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};
   assign w_wmask  = in_pwdata & w_bmask;
   assign w_bm     = w_bmask[NUM_PINS-1:0];
   assign w_wd     = w_wmask[NUM_PINS-1:0];
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_edge   = (w_sync & ~r_prev & r_rise) | (~w_sync & r_prev & ~r_rise);
   assign w_w1c    = (w_wr && (w_addr == AddrStat)) ? w_wd : '0;

   // Address bits above the register map, protection and out-of-range data are don't-care.
   assign w_unused = ^{in_pprot, in_paddr[31:5], in_paddr[1:0], w_wmask, w_bmask};

   assign in_pready  = r_pready;
   assign in_prdata  = r_prdata;
   assign in_pslverr = r_pslverr;
   assign gpio_out   = r_out;
   assign gpio_oe    = r_dir;
   assign irq        = r_irq;

   always_comb begin
      w_rdata = '0;
      case (w_addr)
         AddrOut:   w_rdata[NUM_PINS-1:0] = r_out;
         AddrIn:    w_rdata[NUM_PINS-1:0] = w_sync;
         AddrDir:   w_rdata[NUM_PINS-1:0] = r_dir;
         AddrIrqEn: w_rdata[NUM_PINS-1:0] = r_en;
         AddrRise:  w_rdata[NUM_PINS-1:0] = r_rise;
         AddrStat:  w_rdata[NUM_PINS-1:0] = r_stat;
         default:   w_rdata = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= StIdle;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
      end else begin
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
         case (r_state)
            StIdle: begin
               if (in_psel && !in_penable) r_state <= StAccess;
            end
            StAccess: begin
               if (!in_psel) begin
                  r_state <= StIdle;
               end else if (in_penable) begin
                  r_state   <= StIdle;
                  r_pready  <= 1'b1;
                  r_pslverr <= in_pwrite && (w_addr == AddrIn);
                  r_prdata  <= in_pwrite ? 32'h0 : w_rdata;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev <= '0;
      end else begin
         r_sync[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_sync;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out  <= '0;
         r_dir  <= '0;
         r_en   <= '0;
         r_rise <= '0;
         r_stat <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_irq  <= |(r_stat & r_en);
         // A fresh edge wins over a simultaneous W1C of the same bit.
         r_stat <= (r_stat & ~w_w1c) | w_edge;
         if (w_wr) begin
            case (w_addr)
               AddrOut:    r_out  <= (r_out & ~w_bm) | w_wd;
               AddrDir:    r_dir  <= (r_dir & ~w_bm) | w_wd;
               AddrIrqEn:  r_en   <= (r_en & ~w_bm) | w_wd;
               AddrRise:   r_rise <= (r_rise & ~w_bm) | w_wd;
               AddrOutSet: r_out  <= r_out | w_wd;
               AddrOutClr: r_out  <= r_out & ~w_wd;
               default:    ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gpio_apb_irq.sv
// Randomised scoreboard bench for gpio_apb_irq: a 16-pin and an 8-pin instance on a shared bus.
`timescale 1ns/1ps
module tb_gpio_apb_irq;

   localparam int S = 2;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] paddr = '0;
   logic [1:0]  psel  = '0;
   logic        penable = 1'b0;
   logic [2:0]  pprot = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [15:0] gpio_in = 16'h8000;

   logic [1:0]  rdy, serr, irq_o;
   logic [31:0] rdata0, rdata1;
   logic [15:0] out0, oe0;
   logic [7:0]  out1, oe1;

   always #5 clock = ~clock;

   gpio_apb_irq #(.NUM_PINS(16), .SYNC_STAGES(S)) u_dut0 (
      .clock(clock), .reset(rst), .in_paddr(paddr), .in_psel(psel[0]), .in_penable(penable),
      .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
      .in_pready(rdy[0]), .in_prdata(rdata0), .in_pslverr(serr[0]), .gpio_in(gpio_in),
      .gpio_out(out0), .gpio_oe(oe0), .irq(irq_o[0])
   );

   gpio_apb_irq #(.NUM_PINS(8), .SYNC_STAGES(S)) u_dut1 (
      .clock(clock), .reset(rst), .in_paddr(paddr), .in_psel(psel[1]), .in_penable(penable),
      .in_pprot(pprot), .in_pwrite(pwrite), .in_pwdata(pwdata), .in_pstrb(pstrb),
      .in_pready(rdy[1]), .in_prdata(rdata1), .in_pslverr(serr[1]), .gpio_in(gpio_in[7:0]),
      .gpio_out(out1), .gpio_oe(oe1), .irq(irq_o[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers as plain words, pad history as a delay line.
   logic [31:0] pmask [2];
   logic [31:0] m_out [2], m_dir [2], m_en [2], m_rise [2], m_stat [2];
   logic        m_pready [2], m_irq [2], setup [2];
   logic [15:0] ph [S+1];
   logic [32:0] q0 [$];
   logic [32:0] q1 [$];

   initial begin
      logic [31:0] syn, prv, edg, bm, wd, rd, w1c;
      logic        acc, err;
      pmask[0] = 32'h0000_FFFF;
      pmask[1] = 32'h0000_00FF;
      forever begin
         @(posedge clock);
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               m_out[k] = '0; m_dir[k] = '0; m_en[k] = '0; m_rise[k] = '0; m_stat[k] = '0;
               m_pready[k] = 1'b0; m_irq[k] = 1'b0; setup[k] = 1'b0;
            end else begin
               syn = {16'h0, ph[S-1]} & pmask[k];
               prv = {16'h0, ph[S]} & pmask[k];
               edg = (syn & ~prv & m_rise[k]) | (~syn & prv & ~m_rise[k]);
               m_irq[k] = (m_stat[k] & m_en[k]) != 0;
               acc = psel[k] && penable && setup[k];
               m_pready[k] = acc;
               setup[k] = psel[k] && !penable;
               bm = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
               wd = pwdata & bm & pmask[k];
               w1c = '0; rd = '0; err = 1'b0;
               if (acc) begin
                  if (pwrite) begin
                     case (paddr[4:2])
                        3'd0: m_out[k]  = (m_out[k] & ~bm) | wd;
                        3'd1: err = 1'b1;
                        3'd2: m_dir[k]  = (m_dir[k] & ~bm) | wd;
                        3'd3: m_en[k]   = (m_en[k] & ~bm) | wd;
                        3'd4: m_rise[k] = (m_rise[k] & ~bm) | wd;
                        3'd5: w1c = wd;
                        3'd6: m_out[k]  = m_out[k] | wd;
                        default: m_out[k] = m_out[k] & ~wd;
                     endcase
                     m_out[k] = m_out[k] & pmask[k];
                     m_dir[k] = m_dir[k] & pmask[k];
                     m_en[k] = m_en[k] & pmask[k];
                     m_rise[k] = m_rise[k] & pmask[k];
                  end else begin
                     case (paddr[4:2])
                        3'd0: rd = m_out[k];
                        3'd1: rd = syn;
                        3'd2: rd = m_dir[k];
                        3'd3: rd = m_en[k];
                        3'd4: rd = m_rise[k];
                        3'd5: rd = m_stat[k];
                        default: rd = '0;
                     endcase
                  end
                  if (k == 0) q0.push_back({err, rd});
                  else        q1.push_back({err, rd});
               end
               m_stat[k] = ((m_stat[k] & ~w1c) | edg) & pmask[k];
            end
         end
         if (rst) begin
            for (int i = 0; i <= S; i++) ph[i] = '0;
         end else begin
            for (int i = S; i > 0; i--) ph[i] = ph[i-1];
            ph[0] = gpio_in;
         end
      end
   end

   // Monitor: pops the scoreboard whenever a DUT presents pready.
   initial begin
      logic [32:0] e;
      logic [31:0] rd_act, out_act, oe_act;
      forever begin
         @(negedge clock);
         if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
               rd_act  = (k == 0) ? rdata0 : rdata1;
               out_act = (k == 0) ? {16'h0, out0} : {24'h0, out1};
               oe_act  = (k == 0) ? {16'h0, oe0} : {24'h0, oe1};
               chk($sformatf("pready%0d", k), {31'h0, rdy[k]}, {31'h0, m_pready[k]});
               if (rdy[k]) begin
                  if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                     chk($sformatf("unexpected_ready%0d", k), 32'h1, 32'h0);
                  end else begin
                     e = (k == 0) ? q0.pop_front() : q1.pop_front();
                     chk($sformatf("prdata%0d", k), rd_act, e[31:0]);
                     chk($sformatf("pslverr%0d", k), {31'h0, serr[k]}, {31'h0, e[32]});
                  end
               end else begin
                  chk($sformatf("idle_prdata%0d", k), rd_act, 32'h0);
                  chk($sformatf("idle_pslverr%0d", k), {31'h0, serr[k]}, 32'h0);
               end
               chk($sformatf("gpio_out%0d", k), out_act, m_out[k]);
               chk($sformatf("gpio_oe%0d", k), oe_act, m_dir[k]);
               chk($sformatf("irq%0d", k), {31'h0, irq_o[k]}, {31'h0, m_irq[k]});
            end
         end
      end
   end

   // Called at a negedge; returns at a negedge with the bus idle.
   task automatic apb(input int k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb);
      psel = 2'b00;
      psel[k] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = data;
      pstrb = strb;
      pprot = 3'($urandom);
      @(negedge clock);
      penable = 1'b1;
      @(negedge clock);
      chk("one_wait_state", {31'h0, rdy[k]}, 32'h1);
      @(negedge clock);
      psel = 2'b00;
      penable = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      logic [31:0] a;
      int k;
      idle(1);
      mon_en = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(4);

      for (int i = 0; i < 8; i++) begin
         apb(0, 1'b0, 32'(i * 4), 32'h0, 4'h0);
         apb(1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
      end

      apb(0, 1'b1, 32'h00, 32'h0000_A5A5, 4'b0001);
      chk("out_strobe", {16'h0, out0}, 32'h0000_00A5);
      apb(0, 1'b1, 32'h00, 32'h0000_00F0, 4'hF);
      apb(0, 1'b1, 32'h18, 32'h0000_000F, 4'hF);
      chk("out_set", {16'h0, out0}, 32'h0000_00FF);
      apb(0, 1'b1, 32'h1C, 32'h0000_00F0, 4'hF);
      chk("out_clr", {16'h0, out0}, 32'h0000_000F);
      apb(0, 1'b0, 32'h00, 32'h0, 4'h0);

      apb(0, 1'b1, 32'h04, 32'hFFFF_FFFF, 4'hF);
      apb(0, 1'b0, 32'h04, 32'h0, 4'h0);

      apb(0, 1'b1, 32'h0C, 32'h0000_0009, 4'hF);
      apb(0, 1'b1, 32'h10, 32'h0000_0001, 4'hF);
      apb(0, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF);
      idle(2);
      gpio_in[0] = 1'b1;
      idle(S + 1);
      chk("irq_before_latency", {31'h0, irq_o[0]}, 32'h0);
      idle(1);
      chk("irq_after_latency", {31'h0, irq_o[0]}, 32'h1);
      apb(0, 1'b0, 32'h14, 32'h0, 4'h0);
      apb(0, 1'b1, 32'h14, 32'h0000_0001, 4'hF);
      chk("irq_w1c", {31'h0, irq_o[0]}, 32'h0);

      gpio_in[3] = 1'b1;
      idle(5);
      gpio_in[3] = 1'b0;
      idle(5);
      gpio_in[3] = 1'b1;
      idle(5);
      gpio_in[3] = 1'b0;
      idle(1);
      apb(0, 1'b1, 32'h14, 32'h0000_0008, 4'hF);
      apb(0, 1'b0, 32'h14, 32'h0, 4'h0);
      chk("w1c_vs_edge_irq", {31'h0, irq_o[0]}, 32'h1);
      apb(0, 1'b1, 32'h14, 32'h0000_0008, 4'hF);
      apb(0, 1'b0, 32'h14, 32'h0, 4'h0);

      apb(1, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
      apb(1, 1'b0, 32'h08, 32'h0, 4'h0);
      apb(1, 1'b0, 32'hFFFF_FFE8, 32'h0, 4'h0);

      rst = 1'b1;
      psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFF; pstrb = 4'hF;
      idle(1);
      rst = 1'b0;
      penable = 1'b1;
      idle(1);
      chk("reset_mid_pready", {31'h0, rdy[0]}, 32'h0);
      idle(1);
      psel = 2'b00; penable = 1'b0;
      chk("reset_mid_out", {16'h0, out0}, 32'h0);
      idle(2);

      for (int n = 0; n < 400; n++) begin
         k = int'($urandom_range(0, 1));
         a = $urandom;
         a[4:2] = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ (16'h1 << $urandom_range(0, 15));
         apb(k, 1'($urandom), a, $urandom, 4'($urandom));
         if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
         if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 4)));
      end

      idle(4);
      chk("scoreboard0_drained", 32'(q0.size()), 32'h0);
      chk("scoreboard1_drained", 32'(q1.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
